// File: rtl/mel_filterbank_pkg.sv
// Shared constants, ROM word layout and drain FSM states for the mel filterbank.
package mel_pkg;

    localparam int N_BINS   = 256;
    localparam int NUM_FILT = 32;
    localparam int I_BW     = 32;
    localparam int W_BW     = 9;
    localparam int ACC_BW   = 48;
    localparam int O_BW     = 32;

    localparam int BIN_BW   = $clog2(N_BINS);
    localparam int FIDX_BW  = $clog2(NUM_FILT) + 1;
    localparam int IDX_BW   = $clog2(NUM_FILT);

    // ROM word field offsets, LSB first: {lo_en, hi_en, fidx, w}
    localparam int W_OFF    = 0;
    localparam int FIDX_OFF = W_OFF + W_BW;
    localparam int HI_OFF   = FIDX_OFF + FIDX_BW;
    localparam int LO_OFF   = HI_OFF + 1;
    localparam int ROM_W    = LO_OFF + 1;

    localparam logic [W_BW-1:0] W_UNITY = 9'd256;

    typedef struct packed {
        logic               lo_en;
        logic               hi_en;
        logic [FIDX_BW-1:0] fidx;
        logic [W_BW-1:0]    w;
    } coef_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

endpackage

// File: rtl/mel_filterbank_coef_rom.sv
// Bin index -> triangular filter coefficient. Segment edges grow in four bands
// (widths 2, 4, 8, 16) approximating mel spacing; every segment start is width-aligned.
module mel_coef_rom
    import mel_pkg::*;
(
    input  logic [BIN_BW-1:0] i_bin,
    output coef_t             o_coef
);

    logic [FIDX_BW-1:0] w_seg;
    logic [3:0]         w_lsh;
    logic [BIN_BW-1:0]  w_mask;
    logic [W_BW-1:0]    w_frac;

    // Locate the segment and the fractional position inside it.
    always_comb begin
        w_seg  = 6'd0;
        w_lsh  = 4'd7;
        w_mask = 8'h01;
        if (i_bin < 8'd16) begin
            w_seg  = 6'(i_bin >> 1);
            w_lsh  = 4'd7;
            w_mask = 8'h01;
        end else if (i_bin < 8'd48) begin
            w_seg  = 6'd8 + 6'((i_bin - 8'd16) >> 2);
            w_lsh  = 4'd6;
            w_mask = 8'h03;
        end else if (i_bin < 8'd112) begin
            w_seg  = 6'd16 + 6'((i_bin - 8'd48) >> 3);
            w_lsh  = 4'd5;
            w_mask = 8'h07;
        end else begin
            w_seg  = 6'd24 + 6'((i_bin - 8'd112) >> 4);
            w_lsh  = 4'd4;
            w_mask = 8'h0f;
        end
    end

    assign w_frac       = {1'b0, i_bin & w_mask};
    assign o_coef.w     = w_frac << w_lsh;
    assign o_coef.fidx  = w_seg;
    assign o_coef.hi_en = (w_seg <= FIDX_BW'(NUM_FILT - 1));
    assign o_coef.lo_en = (w_seg != 6'd0);

endmodule

// File: rtl/mel_filterbank.sv
// Mel filterbank: 3-stage MAC pipe into an accumulate bank, copied to a drain bank at frame end.
// Build option MEL_FILTERBANK_SAT_EN selects saturating instead of wrapping output reduction.
module mel_filterbank
    import mel_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            en_i,
    input  logic [I_BW-1:0] data_i,
    input  logic            valid_i,
    input  logic            last_i,
    output logic [O_BW-1:0] data_o,
    output logic            valid_o,
    output logic            last_o,
    output logic            overrun_o
);

    function automatic logic [O_BW-1:0] reduce_acc(input logic [ACC_BW-1:0] acc);
`ifdef MEL_FILTERBANK_SAT_EN
        if (|acc[ACC_BW-1:O_BW+8]) begin
            return {O_BW{1'b1}};
        end else begin
            return acc[O_BW+7:8];
        end
`else
        return acc[O_BW+7:8];
`endif
    endfunction

    logic               w_beat;
    logic [BIN_BW-1:0]  r_bin_cnt;
    logic               r_bin_ovf;
    coef_t              w_coef;
    coef_t              r_s1_coef;
    logic [I_BW-1:0]    r_s1_p;
    logic               r_s1_vld;
    logic               r_s1_last;
    logic [ACC_BW-1:0]  w_prod_hi;
    logic [ACC_BW-1:0]  w_prod_lo;
    logic               r_s2_last;
    logic               r_s2_hi_en;
    logic               r_s2_lo_en;
    logic [FIDX_BW-1:0] r_s2_fidx;
    logic [ACC_BW-1:0]  r_s2_prod_hi;
    logic [ACC_BW-1:0]  r_s2_prod_lo;
    logic [ACC_BW-1:0]  r_acc      [NUM_FILT];
    logic [ACC_BW-1:0]  r_drain    [NUM_FILT];
    logic [ACC_BW-1:0]  w_next_acc [NUM_FILT];
    drain_state_e       r_state;
    drain_state_e       w_state_nxt;
    logic [IDX_BW-1:0]  r_drain_idx;
    logic [IDX_BW-1:0]  w_idx_nxt;
    logic [IDX_BW-1:0]  w_idx_inc;
    logic               w_swap;
    logic               w_busy;
    logic               w_take;
    logic [O_BW-1:0]    w_data_nxt;
    logic               w_valid_nxt;
    logic               w_last_nxt;
    logic               w_ovr_nxt;

    assign w_beat = valid_i & en_i;

    mel_coef_rom u_coef_rom (
        .i_bin  (r_bin_cnt),
        .o_coef (w_coef)
    );

    // Bin counter; once bin N_BINS-1 is consumed, extra beats map to no filter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bin_cnt <= '0;
            r_bin_ovf <= 1'b0;
        end else if (w_beat) begin
            if (last_i) begin
                r_bin_cnt <= '0;
                r_bin_ovf <= 1'b0;
            end else if (r_bin_cnt == BIN_BW'(N_BINS - 1)) begin
                r_bin_ovf <= 1'b1;
            end else begin
                r_bin_cnt <= r_bin_cnt + 8'd1;
            end
        end
    end

    assign w_prod_hi = ACC_BW'(r_s1_coef.w) * ACC_BW'(r_s1_p);
    assign w_prod_lo = ACC_BW'(W_UNITY - r_s1_coef.w) * ACC_BW'(r_s1_p);

    // S1 captures coefficient + power, S2 captures both products.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1_coef    <= '0;
            r_s1_p       <= '0;
            r_s1_vld     <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s2_last    <= 1'b0;
            r_s2_hi_en   <= 1'b0;
            r_s2_lo_en   <= 1'b0;
            r_s2_fidx    <= '0;
            r_s2_prod_hi <= '0;
            r_s2_prod_lo <= '0;
        end else begin
            r_s1_coef    <= '{lo_en: w_coef.lo_en & ~r_bin_ovf, hi_en: w_coef.hi_en & ~r_bin_ovf,
                              fidx: w_coef.fidx, w: w_coef.w};
            r_s1_p       <= data_i;
            r_s1_vld     <= w_beat;
            r_s1_last    <= w_beat & last_i;
            r_s2_last    <= r_s1_last;
            r_s2_hi_en   <= r_s1_vld & r_s1_coef.hi_en;
            r_s2_lo_en   <= r_s1_vld & r_s1_coef.lo_en;
            r_s2_fidx    <= r_s1_coef.fidx;
            r_s2_prod_hi <= w_prod_hi;
            r_s2_prod_lo <= w_prod_lo;
        end
    end

    // S3 read-modify-write view: hi product feeds fidx, lo product feeds fidx-1.
    always_comb begin
        for (int k = 0; k < NUM_FILT; k++) begin
            w_next_acc[k] = r_acc[k]
                + ((r_s2_hi_en && (r_s2_fidx == FIDX_BW'(k)))     ? r_s2_prod_hi : {ACC_BW{1'b0}})
                + ((r_s2_lo_en && (r_s2_fidx == FIDX_BW'(k + 1))) ? r_s2_prod_lo : {ACC_BW{1'b0}});
        end
    end

    assign w_swap    = r_s2_last;
    assign w_busy    = (r_state == ST_DRAIN) && (r_drain_idx != IDX_BW'(NUM_FILT - 1));
    assign w_take    = w_swap & ~w_busy;
    assign w_idx_inc = r_drain_idx + 5'd1;

    // Accumulate bank clears on every frame close, even when the frame is dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NUM_FILT; k++) begin
                r_acc[k]   <= '0;
                r_drain[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_FILT; k++) begin
                r_acc[k] <= w_swap ? {ACC_BW{1'b0}} : w_next_acc[k];
                if (w_take) begin
                    r_drain[k] <= w_next_acc[k];
                end
            end
        end
    end

    // Drain FSM next state and next output word.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_drain_idx;
        w_data_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_ovr_nxt   = w_swap & w_busy;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_nxt = ST_DRAIN;
                    w_idx_nxt   = '0;
                    w_data_nxt  = reduce_acc(w_next_acc[0]);
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_take) begin
                    w_state_nxt = ST_DRAIN;
                    w_idx_nxt   = '0;
                    w_data_nxt  = reduce_acc(w_next_acc[0]);
                    w_valid_nxt = 1'b1;
                end else if (r_drain_idx == IDX_BW'(NUM_FILT - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt   = w_idx_inc;
                    w_data_nxt  = reduce_acc(r_drain[w_idx_inc]);
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (w_idx_inc == IDX_BW'(NUM_FILT - 1));
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Drain state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_drain_idx <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_idx <= w_idx_nxt;
            data_o      <= w_data_nxt;
            valid_o     <= w_valid_nxt;
            last_o      <= w_last_nxt;
            overrun_o   <= w_ovr_nxt;
        end
    end

endmodule

// File: tb/tb_mel_filterbank.sv
// Self-checking bench for mel_filterbank: impulse vector table plus modelled frames.
module tb_mel_filterbank;

    localparam int NF = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        valid;
    logic        last;
    logic [31:0] din;
    logic [31:0] dout;
    logic        vout;
    logic        lout;
    logic        ovr;

    mel_filterbank dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .en_i      (en),
        .data_i    (din),
        .valid_i   (valid),
        .last_i    (last),
        .data_o    (dout),
        .valid_o   (vout),
        .last_o    (lout),
        .overrun_o (ovr)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        int          bin;
        logic [31:0] pwr;
        int          nb;
        int          fa;
        logic [31:0] va;
        int          fb;
        logic [31:0] vb;
    } vec_t;

    exp_t        sb[$];
    int          ovr_q[$];
    logic [31:0] exp_w [NF];
    logic [31:0] frame_p [300];
    int          prev_e = 0;
    bit          have_prev = 1'b0;
    int          edges [34] = '{0, 2, 4, 6, 8, 10, 12, 14, 16,
                                20, 24, 28, 32, 36, 40, 44, 48,
                                56, 64, 72, 80, 88, 96, 104, 112,
                                128, 144, 160, 176, 192, 208, 224, 240, 256};

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, req, edge_cnt);
        end
    endfunction

    function automatic logic [31:0] reduce(longint unsigned a);
        longint unsigned s;
        s = a >> 8;
`ifdef MEL_FILTERBANK_SAT_EN
        if (s > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
`endif
        return s[31:0];
    endfunction

    function automatic void model_frame(int nb);
        longint unsigned acc [NF];
        for (int k = 0; k < NF; k++) acc[k] = 0;
        for (int b = 0; b < nb && b < 256; b++) begin
            int j;
            longint unsigned w;
            j = 0;
            for (int s = 0; s < 33; s++) if (b >= edges[s] && b < edges[s+1]) j = s;
            w = longint'((256 * (b - edges[j])) / (edges[j+1] - edges[j]));
            if (j <= NF - 1) acc[j] += w * frame_p[b];
            if (j >= 1) acc[j-1] += (256 - w) * frame_p[b];
        end
        for (int k = 0; k < NF; k++) exp_w[k] = reduce(acc[k]);
    endfunction

    // Frame closed at acceptance edge e: queue its burst, or an overrun if drain still busy.
    function automatic void schedule(int e);
        exp_t t;
        if (have_prev && (e - prev_e) < 32) begin
            ovr_q.push_back(e + 2);
        end else begin
            prev_e    = e;
            have_prev = 1'b1;
            for (int k = 0; k < NF; k++) begin
                t.due  = e + 2 + k;
                t.data = exp_w[k];
                t.last = (k == NF - 1);
                sb.push_back(t);
            end
        end
    endfunction

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0; en = 1'b1; last = 1'b0; din = 32'd0;
        end
    endtask

    task automatic send_frame(int nb, int pause_mod);
        for (int i = 0; i < nb; i++) begin
            if (pause_mod > 0 && (i % pause_mod) == pause_mod - 1) begin
                @(negedge clk);
                valid = 1'b1; en = 1'b0; last = 1'b1; din = 32'hDEAD_BEEF;
                @(negedge clk);
                valid = 1'b0; en = 1'b1; last = 1'b1; din = 32'hBAD0_0001;
            end
            @(negedge clk);
            valid = 1'b1; en = 1'b1; din = frame_p[i]; last = (i == nb - 1);
        end
        schedule(edge_cnt + 1);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == edge_cnt) begin
            e = sb.pop_front();
            check("valid_o", {63'd0, vout}, 64'd1);
            check("data_o", {32'd0, dout}, {32'd0, e.data});
            check("last_o", {63'd0, lout}, {63'd0, e.last});
        end else begin
            check("idle outputs", {30'd0, vout, lout, dout}, 64'd0);
        end
        if (ovr_q.size() > 0 && ovr_q[0] == edge_cnt) begin
            void'(ovr_q.pop_front());
            check("overrun_o pulse", {63'd0, ovr}, 64'd1);
        end else begin
            check("overrun_o quiet", {63'd0, ovr}, 64'd0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [11];
        int   tgt;

        vt[0]  = '{11,  32'd1000, 40,  4, 32'd500,  5, 32'd500};
        vt[1]  = '{10,  32'd1000, 40,  4, 32'd1000, 5, 32'd0};
        vt[2]  = '{0,   32'd7,    40,  0, 32'd0,    1, 32'd0};
        vt[3]  = '{18,  32'd400,  40,  7, 32'd200,  8, 32'd200};
        vt[4]  = '{19,  32'd4096, 40,  7, 32'd1024, 8, 32'd3072};
        vt[5]  = '{53,  32'd256,  60, 15, 32'd96,  16, 32'd160};
        vt[6]  = '{130, 32'd1024, 140, 24, 32'd896, 25, 32'd128};
        vt[7]  = '{112, 32'd100,  120, 23, 32'd100, 24, 32'd0};
        vt[8]  = '{255, 32'd512,  256, 31, 32'd32,   0, 32'd0};
        vt[9]  = '{17,  32'd3,    40,  7, 32'd2,    8, 32'd0};
        vt[10] = '{5,   32'd0,    256, 0, 32'd0,   31, 32'd0};

        rst_n = 1'b0; valid = 1'b0; en = 1'b0; last = 1'b0; din = 32'd0;
        #1;
        check("reset valid_o", {63'd0, vout}, 64'd0);
        check("reset data_o", {32'd0, dout}, 64'd0);
        check("reset last_o", {63'd0, lout}, 64'd0);
        check("reset overrun_o", {63'd0, ovr}, 64'd0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Impulse table, frames back to back with no gap.
        for (int v = 0; v < 11; v++) begin
            for (int i = 0; i < vt[v].nb; i++) frame_p[i] = 32'd0;
            frame_p[vt[v].bin] = vt[v].pwr;
            for (int k = 0; k < NF; k++) exp_w[k] = 32'd0;
            exp_w[vt[v].fa] = vt[v].va;
            exp_w[vt[v].fb] = vt[v].vb;
            send_frame(vt[v].nb, 0);
        end
        idle(40);

        // Full-scale frame exercising saturation / wrap.
        for (int i = 0; i < 256; i++) frame_p[i] = 32'hFFFF_FFFF;
        model_frame(256);
        send_frame(256, 0);

        // Random frame with en_i pauses and ignored last_i beats, back to back.
        for (int i = 0; i < 256; i++) frame_p[i] = $urandom_range(0, 32'h00FF_FFFF);
        model_frame(256);
        send_frame(256, 7);

        // Oversize frame: beats past bin 255 contribute nothing.
        for (int i = 0; i < 260; i++) frame_p[i] = $urandom();
        model_frame(260);
        send_frame(260, 0);
        idle(40);

        // Two short frames one cycle apart: second one dropped.
        for (int i = 0; i < 8; i++) frame_p[i] = $urandom_range(0, 1000000);
        model_frame(8);
        send_frame(8, 0);
        idle(1);
        for (int i = 0; i < 8; i++) frame_p[i] = $urandom();
        model_frame(8);
        send_frame(8, 0);
        idle(50);

        // Reset while word 10 is on the output.
        for (int i = 0; i < 40; i++) frame_p[i] = $urandom_range(0, 65535);
        model_frame(40);
        send_frame(40, 0);
        tgt = prev_e + 12;
        for (int i = 0; i < 100 && edge_cnt != tgt; i++) idle(1);
        check("reach drain word 10", edge_cnt, tgt);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-drain reset valid_o", {63'd0, vout}, 64'd0);
        check("mid-drain reset last_o", {63'd0, lout}, 64'd0);
        check("mid-drain reset data_o", {32'd0, dout}, 64'd0);
        sb.delete();
        ovr_q.delete();
        have_prev = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 256; i++) frame_p[i] = $urandom_range(0, 32'h0FFF_FFFF);
        model_frame(256);
        send_frame(256, 0);
        idle(60);

        check("scoreboard drained", sb.size(), 64'd0);
        check("overrun queue drained", ovr_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
